// File: rtl/bp_seq.sv
// Minibatch training sequencer: per-sample load / forward wait / accumulate,
// then per-epoch update and accumulator clear, repeated for N_EPOCH epochs.
module bp_seq #(
  parameter int N_SAMPLE = 4,
  parameter int FWD_LAT  = 3,
  parameter int N_EPOCH  = 100,
  parameter int ADDR_W   = 8,
  parameter int EPOCH_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_abort,
  output logic               o_ld,
  output logic [ADDR_W-1:0]  o_addr,
  output logic               o_accu,
  output logic               o_upd,
  output logic               o_acc_clr,
  output logic [EPOCH_W-1:0] o_epoch,
  output logic               o_busy,
  output logic               o_done
);

  localparam int LAT_W = (FWD_LAT > 1) ? $clog2(FWD_LAT) : 1;
  localparam logic [LAT_W-1:0]   LAT_LAST   = LAT_W'(FWD_LAT - 1);
  localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(N_SAMPLE - 1);
  localparam logic [EPOCH_W-1:0] EPOCH_LAST = EPOCH_W'(N_EPOCH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR0,
    S_LOAD,
    S_FWD,
    S_ACCU,
    S_UPD,
    S_CLR,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [LAT_W-1:0]   r_lat;
  logic [LAT_W-1:0]   w_lat_next;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  w_addr_next;
  logic [EPOCH_W-1:0] r_epoch;
  logic [EPOCH_W-1:0] w_epoch_next;
  logic               w_abort;

  logic r_ld;
  logic r_accu;
  logic r_upd;
  logic r_acc_clr;
  logic r_busy;
  logic r_done;

  assign w_abort = i_abort && (r_state != S_IDLE);

  always_comb begin
    w_state_next = r_state;
    w_lat_next   = r_lat;
    w_addr_next  = r_addr;
    w_epoch_next = r_epoch;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_next = S_CLR0;
      end
      S_CLR0: begin
        w_addr_next  = '0;
        w_epoch_next = '0;
        w_state_next = S_LOAD;
      end
      S_LOAD: begin
        w_lat_next   = '0;
        w_state_next = S_FWD;
      end
      S_FWD: begin
        if (r_lat == LAT_LAST) w_state_next = S_ACCU;
        else                   w_lat_next   = r_lat + LAT_W'(1);
      end
      S_ACCU: begin
        if (r_addr == ADDR_LAST) begin
          w_state_next = S_UPD;
        end else begin
          w_addr_next  = r_addr + ADDR_W'(1);
          w_state_next = S_LOAD;
        end
      end
      S_UPD: begin
        w_state_next = S_CLR;
      end
      S_CLR: begin
        w_addr_next  = '0;
        w_epoch_next = r_epoch + EPOCH_W'(1);
        if (r_epoch == EPOCH_LAST) w_state_next = S_DONE;
        else                       w_state_next = S_LOAD;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    // Abort overrides whatever the state scheduled: back to IDLE, epoch count kept.
    if (w_abort) begin
      w_state_next = S_IDLE;
      w_lat_next   = r_lat;
      w_addr_next  = '0;
      w_epoch_next = r_epoch;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lat   <= '0;
      r_addr  <= '0;
      r_epoch <= '0;
    end else begin
      r_state <= w_state_next;
      r_lat   <= w_lat_next;
      r_addr  <= w_addr_next;
      r_epoch <= w_epoch_next;
    end
  end

  // Strobes are registered from the next-state decode so each is high for
  // exactly the cycle spent in its state; abort maps to a lone clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ld      <= 1'b0;
      r_accu    <= 1'b0;
      r_upd     <= 1'b0;
      r_acc_clr <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_ld      <= (w_state_next == S_LOAD);
      r_accu    <= (w_state_next == S_ACCU);
      r_upd     <= (w_state_next == S_UPD);
      r_acc_clr <= (w_state_next == S_CLR0) || (w_state_next == S_CLR) || w_abort;
      r_busy    <= (w_state_next != S_IDLE);
      r_done    <= (w_state_next == S_DONE);
    end
  end

  assign o_ld      = r_ld;
  assign o_accu    = r_accu;
  assign o_upd     = r_upd;
  assign o_acc_clr = r_acc_clr;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_addr    = r_addr;
  assign o_epoch   = r_epoch;

endmodule

// File: tb/tb_bp_seq.sv
// Directed bench for bp_seq: cycle-exact strobe schedule, single-sample config,
// abort, mid-run reset and held-start restart.
module tb_bp_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_start, a_abort;
  logic        a_ld, a_accu, a_upd, a_acc_clr, a_busy, a_done;
  logic [7:0]  a_addr;
  logic [15:0] a_epoch;
  logic        b_start, b_abort;
  logic        b_ld, b_accu, b_upd, b_acc_clr, b_busy, b_done;
  logic [7:0]  b_addr;
  logic [15:0] b_epoch;

  bp_seq #(.N_SAMPLE(4), .FWD_LAT(3), .N_EPOCH(2), .ADDR_W(8), .EPOCH_W(16)) dut_a (
    .clk(clk), .rst(rst), .i_start(a_start), .i_abort(a_abort),
    .o_ld(a_ld), .o_addr(a_addr), .o_accu(a_accu), .o_upd(a_upd),
    .o_acc_clr(a_acc_clr), .o_epoch(a_epoch), .o_busy(a_busy), .o_done(a_done)
  );

  bp_seq #(.N_SAMPLE(1), .FWD_LAT(1), .N_EPOCH(1), .ADDR_W(8), .EPOCH_W(16)) dut_b (
    .clk(clk), .rst(rst), .i_start(b_start), .i_abort(b_abort),
    .o_ld(b_ld), .o_addr(b_addr), .o_accu(b_accu), .o_upd(b_upd),
    .o_acc_clr(b_acc_clr), .o_epoch(b_epoch), .o_busy(b_busy), .o_done(b_done)
  );

  // strobe code: ld=1 accu=2 upd=4 acc_clr=8 done=16
  typedef struct {
    int cyc;
    int strb;
    int addr;   // -1: not checked
    int epoch;  // -1: not checked
  } vec_t;

  vec_t sched[22];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [4:0] strb_a();
    return {a_done, a_acc_clr, a_upd, a_accu, a_ld};
  endfunction

  function automatic logic [4:0] strb_b();
    return {b_done, b_acc_clr, b_upd, b_accu, b_ld};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: start pulse; 1: extra start pulses while busy; 2: start held high
  task automatic run_sched(input string tag, input int mode);
    int idx;
    a_start = 1'b1;
    tick();
    a_start = (mode == 2);
    for (int c = 1; c <= 47; c++) begin
      idx = -1;
      for (int k = 0; k < 22; k++) if (sched[k].cyc == c) idx = k;
      chk($sformatf("%s c%0d strobes", tag, c), strb_a(), (idx >= 0) ? sched[idx].strb : 0);
      chk($sformatf("%s c%0d busy", tag, c), a_busy, (c <= 46) ? 1 : 0);
      if (idx >= 0 && sched[idx].addr >= 0)
        chk($sformatf("%s c%0d addr", tag, c), a_addr, sched[idx].addr);
      if (idx >= 0 && sched[idx].epoch >= 0)
        chk($sformatf("%s c%0d epoch", tag, c), a_epoch, sched[idx].epoch);
      if (mode == 1) a_start = (c == 5 || c == 30 || c == 46);
      tick();
    end
    if (mode == 2) begin
      chk({tag, " restart clr0 strobes"}, strb_a(), 8);
      chk({tag, " restart clr0 busy"}, a_busy, 1);
      chk({tag, " restart clr0 epoch held"}, a_epoch, 2);
      tick();
      chk({tag, " restart ld strobes"}, strb_a(), 1);
      chk({tag, " restart epoch zero"}, a_epoch, 0);
      chk({tag, " restart addr"}, a_addr, 0);
      a_start = 1'b0;
      a_abort = 1'b1;
      tick();
      a_abort = 1'b0;
      chk({tag, " abort strobes"}, strb_a(), 8);
      chk({tag, " abort busy"}, a_busy, 0);
      tick();
      chk({tag, " idle strobes"}, strb_a(), 0);
    end else begin
      chk({tag, " c48 strobes"}, strb_a(), 0);
      chk({tag, " c48 epoch"}, a_epoch, 2);
    end
  endtask

  initial begin
    int b_exp[7];
    b_exp = '{8, 1, 0, 2, 4, 8, 16};
    sched = '{
      '{1, 8, 0, -1}, '{2, 1, 0, 0},  '{6, 2, 0, 0},  '{7, 1, 1, 0},
      '{11, 2, 1, 0}, '{12, 1, 2, 0}, '{16, 2, 2, 0}, '{17, 1, 3, 0},
      '{21, 2, 3, 0}, '{22, 4, 3, 0}, '{23, 8, 3, 0}, '{24, 1, 0, 1},
      '{28, 2, 0, 1}, '{29, 1, 1, 1}, '{33, 2, 1, 1}, '{34, 1, 2, 1},
      '{38, 2, 2, 1}, '{39, 1, 3, 1}, '{43, 2, 3, 1}, '{44, 4, 3, 1},
      '{45, 8, 3, 1}, '{46, 16, 0, 2}
    };

    rst = 1'b1; a_start = 1'b0; a_abort = 1'b0; b_start = 1'b0; b_abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset strobes", strb_a(), 0);
    chk("reset busy", a_busy, 0);
    chk("reset addr", a_addr, 0);
    chk("reset epoch", a_epoch, 0);
    @(negedge clk) rst = 1'b0;
    tick();

    run_sched("run", 0);
    run_sched("busy-start", 1);

    // single-sample, single-epoch configuration
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("n1 c%0d strobes", c), strb_b(), b_exp[c-1]);
      chk($sformatf("n1 c%0d addr", c), b_addr, 0);
      chk($sformatf("n1 c%0d busy", c), b_busy, 1);
      tick();
    end
    chk("n1 c8 busy", b_busy, 0);
    chk("n1 c8 strobes", strb_b(), 0);
    chk("n1 c8 epoch", b_epoch, 1);

    // asynchronous reset in the middle of a forward wait (epoch 2, cycle 26)
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (25) tick();
    chk("pre-rst busy", a_busy, 1);
    chk("pre-rst epoch", a_epoch, 1);
    rst = 1'b1;
    #1;
    chk("mid-rst strobes", strb_a(), 0);
    chk("mid-rst busy", a_busy, 0);
    chk("mid-rst epoch", a_epoch, 0);
    chk("mid-rst addr", a_addr, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    tick();
    chk("post-rst busy", a_busy, 0);
    run_sched("after-rst", 0);

    // abort landing on the accumulate of the second sample (cycle 11)
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (9) tick();
    chk("abort c10 busy", a_busy, 1);
    chk("abort c10 addr", a_addr, 1);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    chk("abort c11 strobes", strb_a(), 8);
    chk("abort c11 busy", a_busy, 0);
    chk("abort c11 addr", a_addr, 0);
    chk("abort c11 epoch", a_epoch, 0);
    tick();
    chk("abort c12 strobes", strb_a(), 0);
    chk("abort c12 busy", a_busy, 0);

    run_sched("held-start", 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
